poci_interconnect: RTL and testbench
====================================

POCI_INTERCONNECT -- requirements
Module: poci_interconnect

Interface
REQ-001 SHALL have parameter NSLV, default 4, meaning number of slave ports (1..16).
REQ-002 SHALL have parameter SLV_BASE, default {40003000,40002000,40001000,40000000} hex, meaning per-slave base address (array [NSLV], 32 bit).
REQ-003 SHALL have parameter SLV_MASK, default FFFFF000 hex for all slaves, meaning per-slave address compare mask.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of wait cycles in the access phase (1..65535).
REQ-005 SHALL have ports pclk  in  1  clock; presetn  in  1  reset.
REQ-006 SHALL have ports m  if_poci.f  -  master side; s[NSLV]  if_poci.n  array  slave side.
REQ-007 SHALL have port err_unmapped  out  1  one-cycle pulse when an unmapped transfer completes.
REQ-008 SHALL have port err_timeout  out  1  one-cycle pulse when a transfer is terminated by timeout.
REQ-009 SHALL have port err_count  out  8  saturating count of all error terminations.
REQ-010 SHALL use one clock (pclk); reset presetn is synchronous and active-low.

Function
REQ-011 Decode SHALL select slave i when m.psel && (m.paddr & SLV_MASK[i]) == SLV_BASE[i]; on overlap the lowest index wins; no match selects the internal default slave.
REQ-012 The selected index SHALL be registered at the end of the setup phase (m.psel && !m.penable) and held for the whole access phase; paddr changes during access SHALL NOT move the selection.
REQ-013 s[i].psel SHALL be combinational from decode in setup and from the registered index in access; at most one s[i].psel high at any time.
REQ-014 paddr, penable, pwrite, pwdata SHALL be broadcast unmodified to all slaves.
REQ-015 FSM states: IDLE, SETUP, ACCESS. IDLE->SETUP on psel&&!penable; SETUP->ACCESS unconditionally; ACCESS->IDLE when m.pready is high and psel is low next; ACCESS->SETUP on back-to-back transfers (psel&&!penable after completion).
REQ-016 In ACCESS to a mapped slave, m.prdata/m.pready/m.pslverr SHALL equal the selected slave's outputs, combinationally (zero added latency).
REQ-017 In ACCESS to the default slave, m.pready SHALL be 1 and m.pslverr SHALL be 1 in the first access cycle, with m.prdata = 0; writes are discarded.
REQ-018 A wait counter SHALL count access cycles with slave pready low; when it reaches TIMEOUT, the interconnect SHALL force m.pready=1, m.pslverr=1, m.prdata=0 for that cycle; the counter SHALL clear on every completion.
REQ-019 When timeout and slave pready coincide in the same cycle, the slave response SHALL win, with no error.
REQ-020 In IDLE, m.pready SHALL be 1, m.pslverr 0, m.prdata 0 (never X).
REQ-021 err_unmapped/err_timeout SHALL pulse in the cycle after the terminating access cycle; err_count SHALL increment by 1 per event and saturate at 255.

Reset
REQ-022 On presetn low at a pclk edge: state IDLE, selected index 0, wait counter 0, err_unmapped 0, err_timeout 0, err_count 0.
REQ-023 Reset mid-transfer SHALL abort the transfer with no error pulse; all s[i].psel SHALL be 0 while presetn is low.

Structure
REQ-024 The FSM state enum and the default-slave index constant SHALL live in pk_poci.
REQ-025 The wait counter with TIMEOUT compare SHALL be the sub-module poci_timeout (ports pclk, presetn, run, clear, expired).

Verification
REQ-026 Write 0x12345678 to 40001004, slave 1 zero-wait -> only s[1].psel is asserted, pwdata is seen at s[1], m.pready=1 in the first access cycle, and pslverr=0.
REQ-027 Read from 50000000 (unmapped) -> m.pready=1, pslverr=1, prdata=0 in the first access cycle, err_unmapped pulses once, and err_count=1.
REQ-028 Read from slave 2 with pready held low forever, TIMEOUT=4 -> the forced pready/pslverr occur on the 4th wait cycle, err_timeout pulses, and the counter clears.
REQ-029 Slave 0 asserts pready on the exact timeout cycle -> slave prdata is returned, pslverr=0, and there is no err pulse.
REQ-030 Back-to-back reads to slave 0 then slave 3, with paddr changed during access -> the selection is held per transfer and both complete correctly.
REQ-031 presetn is asserted low during a waited access -> the FSM is in IDLE, all psel are 0, and err_count is 0 after release.

Source files
------------

// File: rtl/pk_poci.sv
// Shared types and constants for the POCI interconnect and its submodules.
package pk_poci;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // Wide enough for 16 slaves plus one extra code for the default slave.
  localparam int unsigned      IDX_W   = 5;
  localparam logic [IDX_W-1:0] DEF_SLV = 5'd16;

endpackage

// File: rtl/if_poci.sv
// POCI bus bundle; modport f faces the master, modport n faces one slave.
interface if_poci;
  import pk_poci::*;

  // Handshake: a transfer is one setup cycle (psel=1, penable=0) followed by
  // access cycles (psel=1, penable=1); it completes on the first access cycle
  // with pready=1, where prdata/pslverr are valid. Request fields hold steady
  // from setup to completion.
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport f (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport n (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

endinterface

// File: rtl/poci_timeout.sv
// Access-phase wait counter; expired is high on the TIMEOUT-th wait cycle.
module poci_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic pclk,
  input  logic presetn,
  input  logic run,
  input  logic clear,
  output logic expired
);

  logic [15:0] cnt;

  // cnt holds the waits already seen, so the current wait is number cnt+1.
  assign expired = (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/poci_interconnect.sv
// One-master to NSLV-slave POCI interconnect with address decode, an internal
// error slave for unmapped addresses and an access-phase timeout.
module poci_interconnect
  import pk_poci::*;
#(
  parameter int unsigned                    NSLV     = 4,
  parameter logic [NSLV-1:0][ADDR_W-1:0]    SLV_BASE = {32'h40003000, 32'h40002000,
                                                        32'h40001000, 32'h40000000},
  parameter logic [NSLV-1:0][ADDR_W-1:0]    SLV_MASK = {NSLV{32'hFFFFF000}},
  parameter int unsigned                    TIMEOUT  = 255
) (
  input  logic       pclk,
  input  logic       presetn,
  if_poci.f          m,
  if_poci.n          s [NSLV],
  output logic       err_unmapped,
  output logic       err_timeout,
  output logic [7:0] err_count,
  output state_e     state
);

  state_e            state_q;
  logic [IDX_W-1:0]  sel_q;
  logic [IDX_W-1:0]  dec_idx;
  logic [IDX_W-1:0]  cur_idx;
  logic              in_setup;
  logic              in_access;
  logic              mapped;

  logic [NSLV-1:0]   rdy_a;
  logic [NSLV-1:0]   err_a;
  logic [DATA_W-1:0] rdata_a [NSLV];
  logic              slv_ready;
  logic              slv_err;
  logic [DATA_W-1:0] slv_rdata;

  logic              mst_ready;
  logic              mst_err;
  logic [DATA_W-1:0] mst_rdata;

  logic              expired;
  logic              timeout_hit;
  logic              unmapped_done;
  logic              done;
  logic              to_run;
  logic              to_clear;

  // The register only remembers "inside an access phase"; a setup cycle is
  // recognised combinationally so decode adds no latency.
  assign in_access = (state_q == ACCESS) && m.psel;
  assign in_setup  = (state_q != ACCESS) && m.psel && !m.penable;
  assign state     = in_access ? ACCESS : (in_setup ? SETUP : IDLE);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    dec_idx = DEF_SLV;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((m.paddr & SLV_MASK[i]) == SLV_BASE[i]) begin
        dec_idx = IDX_W'(i);
      end
    end
  end

  assign cur_idx = in_access ? sel_q : dec_idx;
  assign mapped  = (sel_q != DEF_SLV);

  for (genvar g = 0; g < NSLV; g++) begin : g_slv
    assign s[g].psel    = presetn && (in_setup || in_access) && (cur_idx == IDX_W'(g));
    assign s[g].penable = m.penable;
    assign s[g].pwrite  = m.pwrite;
    assign s[g].paddr   = m.paddr;
    assign s[g].pwdata  = m.pwdata;
    assign rdy_a[g]     = s[g].pready;
    assign err_a[g]     = s[g].pslverr;
    assign rdata_a[g]   = s[g].prdata;
  end

  always_comb begin
    slv_ready = 1'b0;
    slv_err   = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (sel_q == IDX_W'(i)) begin
        slv_ready = rdy_a[i];
        slv_err   = err_a[i];
        slv_rdata = rdata_a[i];
      end
    end
  end

  // A slave that answers on the timeout cycle wins over the forced error.
  assign timeout_hit   = in_access && mapped && !slv_ready && expired;
  assign unmapped_done = in_access && !mapped;

  always_comb begin
    mst_ready = 1'b1;
    mst_err   = 1'b0;
    mst_rdata = '0;
    if (in_access) begin
      if (!mapped || timeout_hit) begin
        mst_err = 1'b1;
      end else begin
        mst_ready = slv_ready;
        mst_err   = slv_err;
        mst_rdata = slv_rdata;
      end
    end
  end

  assign m.pready  = mst_ready;
  assign m.pslverr = mst_err;
  assign m.prdata  = mst_rdata;

  assign done     = in_access && mst_ready;
  assign to_run   = in_access && mapped && !slv_ready;
  assign to_clear = done || !in_access;

  poci_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .pclk    (pclk),
    .presetn (presetn),
    .run     (to_run),
    .clear   (to_clear),
    .expired (expired)
  );

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      if (in_setup) begin
        state_q <= ACCESS;
        sel_q   <= dec_idx;
      end else if ((state_q == ACCESS) && (!m.psel || done)) begin
        // A master dropping psel mid-access is treated as a silent abort.
        state_q <= IDLE;
      end
      err_unmapped <= unmapped_done;
      err_timeout  <= timeout_hit;
      if ((unmapped_done || timeout_hit) && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_poci_interconnect.sv
// Directed bench for poci_interconnect: master driver task, simple slave
// responders and a response scoreboard fed by the driver.
module tb_poci_interconnect;
  import pk_poci::*;

  localparam int NS = 4;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  if_poci m_if ();
  if_poci s_if [NS] ();

  logic       err_unmapped;
  logic       err_timeout;
  logic [7:0] err_count;
  state_e     state;

  poci_interconnect #(
    .NSLV    (4),
    .TIMEOUT (4)
  ) dut (
    .pclk         (pclk),
    .presetn      (presetn),
    .m            (m_if),
    .s            (s_if),
    .err_unmapped (err_unmapped),
    .err_timeout  (err_timeout),
    .err_count    (err_count),
    .state        (state)
  );

  // ---------------- slave responders ----------------
  // slv_wait: access cycles with pready low before answering; 8'hFF never answers.
  logic [NS-1:0] slv_psel;
  logic [NS-1:0] slv_ready;
  logic [NS-1:0] slv_perr;
  logic [31:0]   slv_rdata [NS];
  logic [7:0]    slv_wait  [NS];
  logic [31:0]   wdata1;
  logic [31:0]   cap_wdata1;

  for (genvar g = 0; g < NS; g++) begin : g_slv
    logic [7:0] acc;
    assign slv_psel[g]      = s_if[g].psel;
    assign slv_ready[g]     = (slv_wait[g] != 8'hFF) && (acc >= slv_wait[g]);
    assign s_if[g].pready   = slv_ready[g];
    assign s_if[g].prdata   = slv_rdata[g];
    assign s_if[g].pslverr  = slv_perr[g];
    always @(posedge pclk) acc <= (slv_psel[g] && m_if.penable) ? acc + 8'd1 : 8'd0;
  end

  assign wdata1 = s_if[1].pwdata;

  always @(negedge pclk) begin
    if (slv_psel[1] && m_if.penable && m_if.pwrite) cap_wdata1 <= wdata1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q [$];   // {slave psel one-hot, pslverr, prdata}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (presetn === 1'b1) begin
      check("psel_onehot", 64'($countones(slv_psel) <= 1), 64'd1);
      if (m_if.psel && m_if.penable && (m_if.pready === 1'b1)) begin
        if (exp_q.size() == 0) check("unexpected_completion", 64'd1, 64'd0);
        else check("response", {slv_psel, m_if.pslverr, m_if.prdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Called at #1 after a rising edge; returns #1 after the completing edge with
  // the bus idle, so consecutive calls form back-to-back transfers.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] acc_addr,
                      input logic wr, input logic [31:0] wdata,
                      input logic [3:0] exp_sel, input logic exp_err,
                      input logic [31:0] exp_rdata, output int waits);
    exp_q.push_back({exp_sel, exp_err, exp_rdata});
    m_if.psel    = 1'b1;
    m_if.penable = 1'b0;
    m_if.paddr   = addr;
    m_if.pwrite  = wr;
    m_if.pwdata  = wdata;
    @(posedge pclk); #1;
    m_if.penable = 1'b1;
    m_if.paddr   = acc_addr;
    waits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (m_if.pready === 1'b1) break;
      waits++;
    end
    if (waits >= 40) check("xfer_bound", 64'd1, 64'd0);
    @(posedge pclk); #1;
    m_if.psel    = 1'b0;
    m_if.penable = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge pclk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    presetn      = 1'b0;
    m_if.psel    = 1'b0;
    m_if.penable = 1'b0;
    m_if.pwrite  = 1'b0;
    m_if.paddr   = '0;
    m_if.pwdata  = '0;
    slv_rdata    = '{32'hA000_0000, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    slv_wait     = '{8'd0, 8'd0, 8'd0, 8'd0};
    slv_perr     = '0;
    cap_wdata1   = '0;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_state",    64'(state), 64'(IDLE));
    check("rst_err_unm",  64'(err_unmapped), 64'd0);
    check("rst_err_to",   64'(err_timeout), 64'd0);
    check("rst_err_cnt",  64'(err_count), 64'd0);
    check("rst_psel",     64'(slv_psel), 64'd0);
    check("idle_resp",    {m_if.pready, m_if.pslverr, m_if.prdata}, {2'b10, 32'd0});
    @(posedge pclk); #1;
    presetn = 1'b1;
    next_cycle();

    // Zero-wait write to slave 1.
    xfer(32'h40001004, 32'h40001004, 1'b1, 32'h12345678, 4'b0010, 1'b0, 32'h1111_0001, w);
    check("wr_waits", 64'(w), 64'd0);
    check("wr_pwdata", 64'(cap_wdata1), 64'h12345678);
    check("wr_no_err", {err_unmapped, err_timeout, err_count}, 64'd0);
    next_cycle();

    // Unmapped read completes at once with an error.
    xfer(32'h50000000, 32'h50000000, 1'b0, 32'd0, 4'b0000, 1'b1, 32'd0, w);
    check("unm_waits", 64'(w), 64'd0);
    check("unm_pulse", {err_unmapped, err_timeout}, 64'b10);
    check("unm_count", 64'(err_count), 64'd1);
    next_cycle();
    check("unm_pulse_end", 64'(err_unmapped), 64'd0);
    check("unm_count_hold", 64'(err_count), 64'd1);

    // Slave 2 never answers: forced completion on the 4th wait cycle.
    slv_wait[2] = 8'hFF;
    xfer(32'h40002008, 32'h40002008, 1'b0, 32'd0, 4'b0100, 1'b1, 32'd0, w);
    check("to_waits", 64'(w), 64'd3);
    check("to_pulse", {err_unmapped, err_timeout}, 64'b01);
    check("to_count", 64'(err_count), 64'd2);
    next_cycle();
    check("to_pulse_end", 64'(err_timeout), 64'd0);

    // A one-wait read after the timeout proves the wait counter cleared.
    slv_wait[2] = 8'd1;
    xfer(32'h40002000, 32'h40002000, 1'b0, 32'd0, 4'b0100, 1'b0, 32'h2222_0002, w);
    check("clr_waits", 64'(w), 64'd1);
    check("clr_no_err", {err_unmapped, err_timeout, err_count}, {2'b00, 8'd2});
    next_cycle();

    // Slave 0 answers on exactly the timeout cycle: slave wins.
    slv_wait[0] = 8'd3;
    xfer(32'h40000000, 32'h40000000, 1'b0, 32'd0, 4'b0001, 1'b0, 32'hA000_0000, w);
    check("edge_waits", 64'(w), 64'd3);
    check("edge_no_err", {err_unmapped, err_timeout, err_count}, {2'b00, 8'd2});
    next_cycle();

    // Slave error response passes straight through.
    slv_perr[1] = 1'b1;
    xfer(32'h40001010, 32'h40001010, 1'b0, 32'd0, 4'b0010, 1'b1, 32'h1111_0001, w);
    check("perr_no_pulse", {err_unmapped, err_timeout}, 64'b00);
    slv_perr[1] = 1'b0;
    next_cycle();

    // Back-to-back reads with paddr moved during the access phase.
    slv_wait[0] = 8'd2;
    xfer(32'h40000010, 32'h40003010, 1'b0, 32'd0, 4'b0001, 1'b0, 32'hA000_0000, w);
    check("b2b0_waits", 64'(w), 64'd2);
    xfer(32'h4000300C, 32'h50000000, 1'b0, 32'd0, 4'b1000, 1'b0, 32'h3333_0003, w);
    check("b2b3_waits", 64'(w), 64'd0);
    check("b2b_no_err", {err_unmapped, err_timeout, err_count}, {2'b00, 8'd2});
    next_cycle();

    // Reset during a waited access aborts it silently.
    slv_wait[2]  = 8'hFF;
    m_if.psel    = 1'b1;
    m_if.penable = 1'b0;
    m_if.paddr   = 32'h40002000;
    m_if.pwrite  = 1'b0;
    next_cycle();
    m_if.penable = 1'b1;
    repeat (2) next_cycle();
    presetn = 1'b0;
    @(negedge pclk);
    check("rstmid_psel", 64'(slv_psel), 64'd0);
    @(posedge pclk); #1;
    m_if.psel    = 1'b0;
    m_if.penable = 1'b0;
    @(negedge pclk);
    check("rstmid_psel2", 64'(slv_psel), 64'd0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(negedge pclk);
    check("rstmid_state", 64'(state), 64'(IDLE));
    check("rstmid_err", {err_unmapped, err_timeout, err_count}, 64'd0);
    check("rstmid_resp", {m_if.pready, m_if.pslverr, m_if.prdata}, {2'b10, 32'd0});
    @(posedge pclk); #1;

    // Fresh transfer after reset.
    xfer(32'h40003000, 32'h40003000, 1'b1, 32'hCAFE_F00D, 4'b1000, 1'b0, 32'h3333_0003, w);
    check("post_rst_waits", 64'(w), 64'd0);
    next_cycle();

    // Error counter saturates at 255.
    for (int i = 0; i < 255; i++) begin
      xfer(32'h60000000, 32'h60000000, 1'b0, 32'd0, 4'b0000, 1'b1, 32'd0, w);
    end
    check("sat_255", 64'(err_count), 64'd255);
    xfer(32'h60000000, 32'h60000000, 1'b0, 32'd0, 4'b0000, 1'b1, 32'd0, w);
    check("sat_hold", 64'(err_count), 64'd255);
    check("sat_pulse", 64'(err_unmapped), 64'd1);

    repeat (3) next_cycle();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
